// File: rtl/conv_pipe_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution pipeline sequencer and its datapath:
//   - sched_state_t : sequencer state encoding (IDLE, LOAD, DRAIN, DONE)
//   - num_out()     : number of full-window outputs produced per job
//   - default sizes : X length, filter length, counter width and the datapath
//                     register depth derived from the multiplier/adder stages
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int X_SIZE_DEF  = 128;
  localparam int F_SIZE_DEF  = 32;
  localparam int CNT_W_DEF   = 8;

  // Datapath depth: multiplier pipeline followed by a binary adder tree plus
  // its output register. The last multiplier register also serves as the
  // adder tree's input register, so one stage is shared between the two.
  localparam int MULT_STAGES      = 4;
  localparam int ADD_STAGES       = $clog2(F_SIZE_DEF) + 1;
  localparam int PLINE_STAGES_DEF = MULT_STAGES + ADD_STAGES - 1;

  // A window of f_size taps slides over x_size samples; only positions where
  // the whole window lies inside the input produce an output.
  function automatic int num_out(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

endpackage

// File: rtl/conv_pipe_sched_if.sv
// -----------------------------------------------------------------------------
// conv_pipe_sched_if
// Control/handshake bundle between the sequencer and its environment
// (filter loader, X AXI-stream source, datapath, Y AXI-stream sink).
//   conv_start      : filter memory full (level)
//   s_valid_x/ready : X input stream handshake
//   xmem_wr_en      : X shift-memory write strobe
//   en_pline_stages : global advance enable for every datapath register
//   pline_clear     : synchronous clear for datapath registers
//   m_valid_y/ready : Y output stream handshake
//   conv_done       : one-cycle pulse after the final Y handshake
//   busy            : sequencer is not idle
// modport master : the sequencer side
// modport slave  : the environment side
// -----------------------------------------------------------------------------
interface conv_pipe_sched_if;

  logic conv_start;
  logic s_valid_x;
  logic s_ready_x;
  logic xmem_wr_en;
  logic en_pline_stages;
  logic pline_clear;
  logic m_valid_y;
  logic m_ready_y;
  logic conv_done;
  logic busy;

  modport master (
    input  conv_start, s_valid_x, m_ready_y,
    output s_ready_x, xmem_wr_en, en_pline_stages, pline_clear,
           m_valid_y, conv_done, busy
  );

  modport slave (
    output conv_start, s_valid_x, m_ready_y,
    input  s_ready_x, xmem_wr_en, en_pline_stages, pline_clear,
           m_valid_y, conv_done, busy
  );

endinterface

// File: rtl/conv_vld_pipe.sv
// -----------------------------------------------------------------------------
// conv_vld_pipe
// Valid-token shift register that mirrors the datapath register chain. Each
// bit says whether the matching datapath stage holds a full-window result.
// Parameters:
//   DEPTH   : number of datapath register stages tracked
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous reset, active-low
//   en      : advance enable (shared with the datapath)
//   clr     : synchronous clear, wins over en
//   din     : token entering stage 0 on an advance
//   tail_vld: token state of the final stage
//   any_vld : at least one token is in flight
// -----------------------------------------------------------------------------
module conv_vld_pipe #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic tail_vld,
  output logic any_vld
);

  logic [DEPTH-1:0] vld;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        vld <= '0;
      end else if (en) begin
        vld <= din;
      end
    end
  end else begin : g_chain
    // NOTE: registers are updated with non-blocking assignments so every
    // stage shifts from its neighbour's pre-edge value, never the new one.
    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        vld <= '0;
      end else if (en) begin
        vld <= {vld[DEPTH-2:0], din};
      end
    end
  end

  assign tail_vld = vld[DEPTH-1];
  assign any_vld  = |vld;

endmodule

// File: rtl/conv_pipe_sched.sv
// -----------------------------------------------------------------------------
// conv_pipe_sched
// Sequencer for the pipelined X*F convolution datapath. Once the filter memory
// is full it admits X_SIZE samples, tags every write that completes a full
// window, follows those tokens through the datapath and stalls the whole
// pipeline when the Y sink back-pressures a valid result. After NUM_OUT Y
// handshakes it pulses conv_done, which also clears the filter-load logic.
//
// Parameters:
//   X_SIZE       : X samples per job
//   F_SIZE       : filter taps (window size)
//   PLINE_STAGES : datapath register depth from X write to Y output
//   CNT_W        : counter width, at least $clog2(X_SIZE+1)
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous reset, active-low
//   bus          : conv_pipe_sched_if.master handshake/control bundle
//   stall_cycles : [15:0] busy cycles spent stalled (optional, see below)
//
// Optional build macro CONV_PIPE_SCHED_PERF_EN adds stall_cycles: a saturating
// count of cycles with busy && !en_pline_stages, cleared on reset and on entry
// to LOAD, held while idle. Without the macro the port and counter are absent.
// -----------------------------------------------------------------------------
module conv_pipe_sched
  import conv_pkg::*;
#(
  parameter int X_SIZE       = X_SIZE_DEF,
  parameter int F_SIZE       = F_SIZE_DEF,
  parameter int PLINE_STAGES = PLINE_STAGES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_pipe_sched_if.master bus
`ifdef CONV_PIPE_SCHED_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int NUM_OUT = num_out(X_SIZE, F_SIZE);

  localparam logic [CNT_W-1:0] IN_FULL     = CNT_W'(X_SIZE);
  localparam logic [CNT_W-1:0] WIN_FIRST   = CNT_W'(F_SIZE - 1);
  localparam logic [CNT_W-1:0] OUT_FULL    = CNT_W'(NUM_OUT);
  localparam logic [CNT_W-1:0] OUT_LAST_M1 = CNT_W'(NUM_OUT - 1);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  logic busy;
  logic pline_clear;
  logic conv_done;
  logic tail_vld;
  logic any_vld;
  logic en;
  logic s_ready;
  logic wr;
  logic tok;
  logic y_hs;

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // conv_start is only looked at in IDLE, so dropping it mid-job has no effect
  // and a request seen during DONE waits for the return to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_next  = state;
    busy        = 1'b1;
    pline_clear = 1'b0;
    conv_done   = 1'b0;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        pline_clear = 1'b1;
        if (bus.conv_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (in_cnt == IN_FULL) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (y_hs && (out_cnt == OUT_LAST_M1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        pline_clear = 1'b1;
        conv_done   = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall and admission
  // The whole datapath advances in lock-step; the only reason to hold it is a
  // valid result at the tail that the sink is not taking this cycle. The
  // enable is combinational from m_ready_y so a ready sink never loses a cycle.
  // ---------------------------------------------------------------------------
  assign en      = busy && (!tail_vld || bus.m_ready_y);
  assign s_ready = (state == LOAD) && en && (in_cnt < IN_FULL);
  assign wr      = bus.s_valid_x && s_ready;
  // A write completes a window once F_SIZE-1 samples are already stored.
  assign tok     = wr && (in_cnt >= WIN_FIRST);
  assign y_hs    = tail_vld && bus.m_ready_y;

  // ---------------------------------------------------------------------------
  // Sample and output counters; both restart from zero for every job and
  // saturate at their final value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE)) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (wr) begin
        in_cnt <= in_cnt + CNT_W'(1);
      end
      if (y_hs && (out_cnt != OUT_FULL)) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Token tracker, shifting exactly when the datapath does. Advance cycles
  // without a window-completing write insert empty slots.
  // ---------------------------------------------------------------------------
  conv_vld_pipe #(
    .DEPTH (PLINE_STAGES)
  ) u_vld_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (pline_clear),
    .din      (tok),
    .tail_vld (tail_vld),
    .any_vld  (any_vld)
  );

  // The last token is the last output, so nothing may still be in flight by
  // the time the job completes.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state == DONE) |-> !any_vld);

  // ---------------------------------------------------------------------------
  // Optional stall-cycle counter
  // ---------------------------------------------------------------------------
`ifdef CONV_PIPE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && (state_next == LOAD)) begin
      stall_cycles <= '0;
    end else if (busy && !en && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------------
  assign bus.s_ready_x       = s_ready;
  assign bus.xmem_wr_en      = wr;
  assign bus.en_pline_stages = en;
  assign bus.pline_clear     = pline_clear;
  assign bus.m_valid_y       = tail_vld;
  assign bus.conv_done       = conv_done;
  assign bus.busy            = busy;

endmodule

// File: tb/tb_conv_pipe_sched.sv
// -----------------------------------------------------------------------------
// tb_conv_pipe_sched
// Self-checking bench for conv_pipe_sched at default sizes. A directed vector
// table covers reset, start gating and the first LOAD cycles; full jobs are
// then driven with nominal, back-pressured, bubbly and aborted traffic while a
// behavioural model (in-flight token ages held in a queue) predicts every
// control output each cycle. Build with CONV_PIPE_SCHED_PERF_EN to also check
// stall_cycles.
// -----------------------------------------------------------------------------
module tb_conv_pipe_sched;
  import conv_pkg::*;

  localparam int X    = X_SIZE_DEF;
  localparam int F    = F_SIZE_DEF;
  localparam int P    = PLINE_STAGES_DEF;
  localparam int NOUT = X - F + 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_pipe_sched_if bus ();

`ifdef CONV_PIPE_SCHED_PERF_EN
  logic [15:0] stall_cycles;
`endif

  conv_pipe_sched #(
    .X_SIZE       (X),
    .F_SIZE       (F),
    .PLINE_STAGES (P),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CONV_PIPE_SCHED_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: job phase, accepted/emitted counts and the age of every
  // window result in flight (age P means it sits at the output).
  // ---------------------------------------------------------------------------
  int m_phase, m_in, m_out, m_stall;
  int ages[$];
  logic e_mvalid, e_busy, e_en, e_sready, e_wr, e_tok, e_clear, e_done;

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_in    = 0;
    m_out   = 0;
    m_stall = 0;
    ages.delete();
  endtask

  function automatic logic model_mvalid();
    return (ages.size() > 0) && (ages[0] == P);
  endfunction

  task automatic model_comb();
    e_mvalid = model_mvalid();
    e_busy   = (m_phase != PH_IDLE);
    e_en     = e_busy && (!e_mvalid || bus.m_ready_y);
    e_sready = (m_phase == PH_LOAD) && e_en && (m_in < X);
    e_wr     = bus.s_valid_x && e_sready;
    e_tok    = e_wr && (m_in + 1 >= F);
    e_clear  = (m_phase == PH_IDLE) || (m_phase == PH_DONE);
    e_done   = (m_phase == PH_DONE);
  endtask

  task automatic model_edge();
    logic hs;
    int   nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hs  = e_mvalid && bus.m_ready_y;
    nxt = m_phase;
    case (m_phase)
      PH_IDLE:  if (bus.conv_start) nxt = PH_LOAD;
      PH_LOAD:  if (m_in == X) nxt = PH_DRAIN;
      PH_DRAIN: if (hs && (m_out == NOUT - 1)) nxt = PH_DONE;
      default:  nxt = PH_IDLE;
    endcase
    if ((m_phase == PH_IDLE) && bus.conv_start) m_stall = 0;
    else if (e_busy && !e_en && (m_stall < 65535)) m_stall++;
    if (e_clear) begin
      ages.delete();
    end else if (e_en) begin
      if (hs) ages.delete(0);
      foreach (ages[i]) ages[i]++;
      if (e_tok) ages.push_back(1);
    end
    if (m_phase == PH_IDLE) begin
      m_in  = 0;
      m_out = 0;
    end else begin
      if (e_wr) m_in++;
      if (hs && (m_out < NOUT)) m_out++;
    end
    m_phase = nxt;
  endtask

  // ---------------------------------------------------------------------------
  // Per-job observations of the DUT
  // ---------------------------------------------------------------------------
  int n_wr, n_hs, n_done, n_stall_obs, bad_stall;
  int start_cyc, first_wr_cyc, wr_f_cyc, first_valid_cyc;
  int first_hs_cyc, last_hs_cyc, done_cyc, stall_at_done;

  task automatic clear_stats();
    n_wr = 0; n_hs = 0; n_done = 0; n_stall_obs = 0; bad_stall = 0;
    start_cyc = -1; first_wr_cyc = -1; wr_f_cyc = -1; first_valid_cyc = -1;
    first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1; stall_at_done = -1;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model 1 time unit later, then let both advance on the rising edge.
  task automatic step(input logic r, input logic st, input logic sv, input logic mr);
    rst_n          = r;
    bus.conv_start = st;
    bus.s_valid_x  = sv;
    bus.m_ready_y  = mr;
    #1;
    model_comb();
    check_bit("s_ready_x",       bus.s_ready_x,       e_sready);
    check_bit("xmem_wr_en",      bus.xmem_wr_en,      e_wr);
    check_bit("en_pline_stages", bus.en_pline_stages, e_en);
    check_bit("m_valid_y",       bus.m_valid_y,       e_mvalid);
    check_bit("conv_done",       bus.conv_done,       e_done);
    check_bit("busy",            bus.busy,            e_busy);
    check_bit("pline_clear",     bus.pline_clear,     e_clear);
`ifdef CONV_PIPE_SCHED_PERF_EN
    check_int("stall_cycles", int'(stall_cycles), m_stall);
`endif
    if (bus.xmem_wr_en === 1'b1) begin
      n_wr++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (n_wr == F) wr_f_cyc = cyc;
    end
    if ((bus.m_valid_y === 1'b1) && (first_valid_cyc < 0)) first_valid_cyc = cyc;
    if ((bus.m_valid_y === 1'b1) && (bus.m_ready_y === 1'b1)) begin
      n_hs++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    if ((bus.m_valid_y === 1'b1) && !mr) begin
      n_stall_obs++;
      if ((bus.en_pline_stages !== 1'b0) || (bus.s_ready_x !== 1'b0)) bad_stall++;
    end
    if (bus.conv_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
`ifdef CONV_PIPE_SCHED_PERF_EN
      stall_at_done = int'(stall_cycles);
`endif
    end
    cyc++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // mode 0 nominal, 1 ready pattern 1-0-0-1, 2 random bubbles, 3 ten-cycle
  // sink stall from the first valid result. abort_at > 0 pulses reset once
  // that many Y handshakes have been seen.
  task automatic run_job(input int mode, input int abort_at);
    bit seen;
    bit finished;
    int k;
    seen = 0; finished = 0; k = 0;
    clear_stats();
    start_cyc = cyc;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      logic st, sv, mr;
      if (model_mvalid()) seen = 1;
      st = 1'($urandom_range(0, 1));
      sv = 1'b1;
      mr = 1'b1;
      case (mode)
        1: if (seen) begin mr = ((k % 4) == 0) || ((k % 4) == 3); k++; end
        2: begin
          sv = ($urandom_range(0, 99) < 30);
          mr = ($urandom_range(0, 99) < 80);
        end
        3: if (seen) begin mr = (k >= 10); k++; end
        default: ;
      endcase
      step(1'b1, st, sv, mr);
      if (n_done > 0) begin
        finished = 1;
        break;
      end
      if ((abort_at > 0) && (n_hs == abort_at)) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        finished = 1;
        break;
      end
    end
    if (!finished) check_bit("job_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_full_job(input string tag);
    check_int({tag, "_handshakes"}, n_hs, NOUT);
    check_int({tag, "_writes"}, n_wr, X);
    check_int({tag, "_done_pulses"}, n_done, 1);
    check_bit({tag, "_returns_idle"}, bus.busy, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: reset state, start gating and the first LOAD cycles
  // ---------------------------------------------------------------------------
  typedef struct {
    logic rst, start, sv, mr;
    logic e_sready, e_wr, e_en, e_busy, e_clear, e_mvalid, e_done;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  initial begin
    //             rst  st   sv   mr   | srdy wr   en   busy clr  mval done
    vecs[0] = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[2] = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[3] = '{1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[5] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[7] = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};

    rst_n          = 1'b0;
    bus.conv_start = 1'b0;
    bus.s_valid_x  = 1'b0;
    bus.m_ready_y  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();

    for (int i = 0; i < NVEC; i++) begin
      rst_n          = vecs[i].rst;
      bus.conv_start = vecs[i].start;
      bus.s_valid_x  = vecs[i].sv;
      bus.m_ready_y  = vecs[i].mr;
      #1;
      check_bit($sformatf("vec%0d_s_ready_x", i),   bus.s_ready_x,       vecs[i].e_sready);
      check_bit($sformatf("vec%0d_xmem_wr_en", i),  bus.xmem_wr_en,      vecs[i].e_wr);
      check_bit($sformatf("vec%0d_en_pline", i),    bus.en_pline_stages, vecs[i].e_en);
      check_bit($sformatf("vec%0d_busy", i),        bus.busy,            vecs[i].e_busy);
      check_bit($sformatf("vec%0d_pline_clear", i), bus.pline_clear,     vecs[i].e_clear);
      check_bit($sformatf("vec%0d_m_valid_y", i),   bus.m_valid_y,       vecs[i].e_mvalid);
      check_bit($sformatf("vec%0d_conv_done", i),   bus.conv_done,       vecs[i].e_done);
      @(posedge clk);
      @(negedge clk);
    end

    // Start gating: offered samples are refused while conv_start is low.
    clear_stats();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check_int("gated_writes", n_wr, 0);

    // Nominal job: continuous input, always-ready sink.
    run_job(0, 0);
    check_int("nom_first_write_after_start", first_wr_cyc, start_cyc + 1);
    check_int("nom_first_valid_latency", first_valid_cyc - wr_f_cyc, P);
    check_int("nom_hs_consecutive", last_hs_cyc - first_hs_cyc, NOUT - 1);
    check_int("nom_done_after_last_hs", done_cyc, last_hs_cyc + 1);
    check_full_job("nom");
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Back-pressure with ready pattern 1-0-0-1.
    run_job(1, 0);
    check_full_job("bp");
    check_bit("bp_stalls_seen", n_stall_obs > 0, 1'b1);
    check_int("bp_stall_gating", bad_stall, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Input bubbles at ~30% valid with a mostly-ready sink.
    run_job(2, 0);
    check_full_job("bub");
    check_bit("bub_no_early_valid", first_valid_cyc > wr_f_cyc, 1'b1);
    check_int("bub_stall_gating", bad_stall, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset after 50 outputs: everything back to idle, no completion pulse.
    run_job(0, 50);
    check_int("abort_no_done", n_done, 0);
    check_bit("abort_busy", bus.busy, 1'b0);
    check_bit("abort_m_valid_y", bus.m_valid_y, 1'b0);
    check_bit("abort_s_ready_x", bus.s_ready_x, 1'b0);
    check_bit("abort_pline_clear", bus.pline_clear, 1'b1);
    check_bit("abort_en_pline", bus.en_pline_stages, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    // A full job after the abort completes normally.
    run_job(0, 0);
    check_full_job("post_abort");
    step(1'b1, 1'b0, 1'b0, 1'b1);

`ifdef CONV_PIPE_SCHED_PERF_EN
    // Ten cycles of sink stall on a held valid result.
    run_job(3, 0);
    check_full_job("perf");
    check_int("perf_stall_at_done", stall_at_done, 10);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_int("perf_hold_idle", int'(stall_cycles), 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
